read_bank: RTL and testbench

Parallel-read counterpart of the write bank. A fill FSM receives a byte-serial stream from the memory interface with a valid/ready handshake. It distributes the bytes row-major across BANK_WIDTH byte-wide RAM lanes: lane 0..BANK_WIDTH-1 at address 0, then address 1, and so on. Once filled, one address read returns all BANK_WIDTH lanes at once, feeding the FPU array one row per cycle.

---
 rtl/read_bank_pkg.sv | 16 +
 rtl/read_bank_single_ram.sv | 24 ++
 rtl/read_bank.sv | 140 ++++++++++++++
 tb/tb_read_bank.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/read_bank_pkg.sv
// Shared definitions for the read-bank fill controller (also used by the write-bank controller).
package read_bank_pkg;

    // Fill controller states.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFill = 2'd1,
        StDone = 2'd2
    } rb_state_e;

    // Clamp a requested row count to the lane RAM depth.
    function automatic int unsigned sat_rows(input int unsigned rows, input int unsigned depth);
        return (rows > depth) ? depth : rows;
    endfunction

endpackage

// File: rtl/read_bank_single_ram.sv
// Single-port byte-lane RAM: synchronous write, registered read, one shared address.
module read_bank_single_ram #(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write on wr, read the same address every cycle (contents are never reset).
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/read_bank.sv
// Read bank: fills BANK_WIDTH byte lanes row-major from a byte stream, then serves whole rows.
module read_bank
    import read_bank_pkg::*;
#(
    parameter int unsigned BANK_WIDTH             = 10,
    parameter int unsigned MEM_BUFFER_DEPTH_BYTES = 512,
    localparam int unsigned AW                    = $clog2(MEM_BUFFER_DEPTH_BYTES)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [AW:0]                rows,
    input  logic                       in_valid,
    input  logic [7:0]                 in_data,
    output logic                       in_ready,
    output logic                       busy,
    output logic                       done,
    input  logic [AW-1:0]              rd_addr,
    output logic [BANK_WIDTH-1:0][7:0] data_out
);

    // Row counter is one bit wider than the address so a full-depth fill can reach its limit.
    localparam int unsigned RW = AW + 1;
    localparam int unsigned LW = (BANK_WIDTH > 1) ? $clog2(BANK_WIDTH) : 1;
    localparam logic [LW-1:0] LaneLast = LW'(BANK_WIDTH - 1);

    rb_state_e state_q, state_d;

    logic [LW-1:0]         lane_cnt_q;
    logic [RW-1:0]         row_cnt_q;
    logic [RW-1:0]         limit_q;
    logic [RW-1:0]         rows_sat;
    logic                  accept;
    logic                  lane_last;
    logic                  row_last;
    logic [AW-1:0]         ram_addr;
    logic [BANK_WIDTH-1:0] lane_wr;

    assign rows_sat  = RW'(sat_rows(32'(rows), MEM_BUFFER_DEPTH_BYTES));
    assign accept    = (state_q == StFill) && in_valid;
    assign lane_last = (lane_cnt_q == LaneLast);
    assign row_last  = (row_cnt_q == (limit_q - RW'(1)));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start is only looked at in idle, in_valid only in fill.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (rows_sat == '0) ? StDone : StFill;
                end
            end
            StFill: begin
                if (accept && lane_last && row_last) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs depend on state only, so in_ready has no path from in_valid.
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            StIdle: begin
            end
            StFill: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            StDone: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Lane/row counters and row limit; cleared and latched on an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_cnt_q <= '0;
            row_cnt_q  <= '0;
            limit_q    <= '0;
        end else if ((state_q == StIdle) && start) begin
            lane_cnt_q <= '0;
            row_cnt_q  <= '0;
            limit_q    <= rows_sat;
        end else if (accept) begin
            if (lane_last) begin
                lane_cnt_q <= '0;
                row_cnt_q  <= row_cnt_q + RW'(1);
            end else begin
                lane_cnt_q <= lane_cnt_q + LW'(1);
            end
        end
    end

    // Shared address: the fill row while busy, otherwise the external read address.
    always_comb begin
        ram_addr = rd_addr;
        if (busy) begin
            ram_addr = row_cnt_q[AW-1:0];
        end
    end

    for (genvar g = 0; g < BANK_WIDTH; g++) begin : g_lane
        assign lane_wr[g] = accept && (lane_cnt_q == LW'(g));

        read_bank_single_ram #(
            .DEPTH(MEM_BUFFER_DEPTH_BYTES),
            .WIDTH(8)
        ) u_ram (
            .clk (clk),
            .wr  (lane_wr[g]),
            .addr(ram_addr),
            .din (in_data),
            .dout(data_out[g])
        );
    end

endmodule

// File: tb/tb_read_bank.sv
// Directed bench for read_bank with a row-readback scoreboard.
module tb_read_bank;

    localparam int BW    = 10;
    localparam int DEPTH = 512;
    localparam int AW    = 9;
    localparam int RW    = AW + 1;
    localparam int DW    = BW * 8;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic [RW-1:0]       rows;
    logic                in_valid;
    logic [7:0]          in_data;
    logic                in_ready;
    logic                busy;
    logic                done;
    logic [AW-1:0]       rd_addr;
    logic [BW-1:0][7:0]  data_out;

    int n_tests = 0;
    int n_fail  = 0;

    // Bench model of RAM contents, written as the bench streams bytes.
    logic [7:0]    exp_mem [DEPTH][BW];
    logic [DW-1:0] sb_q [$];

    always #5 clk = ~clk;

    read_bank #(
        .BANK_WIDTH(BW),
        .MEM_BUFFER_DEPTH_BYTES(DEPTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .rows    (rows),
        .in_valid(in_valid),
        .in_data (in_data),
        .in_ready(in_ready),
        .busy    (busy),
        .done    (done),
        .rd_addr (rd_addr),
        .data_out(data_out)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] bv(input int idx, input int seed);
        return 8'(idx + seed);
    endfunction

    function automatic logic [DW-1:0] exp_row(input int a);
        logic [DW-1:0] r;
        for (int i = 0; i < BW; i++) r[i*8 +: 8] = exp_mem[a][i];
        return r;
    endfunction

    // Start a fill and stream bytes; checks the done cycle (counted from the start cycle).
    task automatic fill(input string tag, input int rows_in, input bit gaps, input int seed,
                        input int restart_at, input int exp_done);
        int nb;
        int idx;
        int got;
        bit v;
        nb    = ((rows_in > DEPTH) ? DEPTH : rows_in) * BW;
        start = 1'b1;
        rows  = RW'(rows_in);
        in_valid = 1'b0;
        tick();
        start = 1'b0;
        idx   = 0;
        got   = -1;
        for (int cyc = 1; cyc < exp_done + 20; cyc++) begin
            if (done === 1'b1) begin
                got = cyc;
                break;
            end
            if (cyc == 1 && nb > 0) begin
                chk({tag, " in_ready in fill"}, DW'(in_ready), DW'(1));
                chk({tag, " busy in fill"}, DW'(busy), DW'(1));
            end
            start    = (cyc == restart_at);
            rows     = RW'(1);
            v        = !gaps || (cyc % 2 == 1);
            in_valid = v;
            in_data  = bv(idx, seed);
            if (v && idx < nb) begin
                exp_mem[idx / BW][idx % BW] = in_data;
                idx++;
            end
            tick();
        end
        start    = 1'b0;
        in_valid = 1'b0;
        chk({tag, " done cycle"}, DW'(got), DW'(exp_done));
        tick();
        chk({tag, " done one cycle"}, DW'(done), DW'(0));
        chk({tag, " busy after done"}, DW'(busy), DW'(0));
    endtask

    // Issue up to three back-to-back reads; each result is compared one cycle later.
    task automatic rd_stream(input string tag, input int a0, input int a1, input int a2,
                             input int n);
        int addrs [3];
        addrs = '{a0, a1, a2};
        for (int i = 0; i <= n; i++) begin
            if (i > 0) chk($sformatf("%s row %0d", tag, addrs[i-1]), data_out, sb_q.pop_front());
            if (i < n) begin
                rd_addr = AW'(addrs[i]);
                sb_q.push_back(exp_row(addrs[i]));
            end
            tick();
        end
    endtask

    // Row 1 of a seed-0 two-row fill must read 0x0A..0x13 on lanes 0..9.
    task automatic chk_row1_const(input string tag);
        logic [DW-1:0] c;
        for (int i = 0; i < BW; i++) c[i*8 +: 8] = 8'h0A + 8'(i);
        rd_addr = AW'(1);
        tick();
        chk(tag, data_out, c);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        rows     = '0;
        in_valid = 1'b0;
        in_data  = '0;
        rd_addr  = '0;
        #1;
        chk("reset in_ready", DW'(in_ready), DW'(0));
        chk("reset busy", DW'(busy), DW'(0));
        chk("reset done", DW'(done), DW'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Basic two-row fill, bytes 0x00..0x13.
        fill("basic", 2, 1'b0, 0, 0, 21);
        chk_row1_const("basic row1 const");
        rd_stream("basic rd", 0, 1, 0, 3);

        // Oversized request saturates to the full depth.
        fill("sat", 600, 1'b0, 8'h33, 0, DEPTH * BW + 1);
        rd_stream("sat rd", 0, 511, 300, 3);

        // Zero rows: immediate done, contents untouched.
        fill("zero", 0, 1'b0, 8'h77, 0, 1);
        rd_stream("zero rd", 0, 511, 1, 3);

        // Backpressure on every other cycle plus an ignored start mid-fill.
        fill("gaps", 2, 1'b1, 0, 5, 40);
        chk_row1_const("gaps row1 const");
        rd_stream("gaps rd", 0, 1, 0, 3);

        // Reset after 15 bytes of a three-row fill.
        start = 1'b1;
        rows  = RW'(3);
        tick();
        start = 1'b0;
        for (int k = 0; k < 15; k++) begin
            in_valid = 1'b1;
            in_data  = bv(k, 8'h90);
            exp_mem[k / BW][k % BW] = in_data;
            tick();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("midreset in_ready", DW'(in_ready), DW'(0));
        chk("midreset busy", DW'(busy), DW'(0));
        chk("midreset done", DW'(done), DW'(0));
        tick();
        chk("midreset done held", DW'(done), DW'(0));
        rst_n = 1'b1;
        tick();
        chk("post reset busy", DW'(busy), DW'(0));
        chk("post reset done", DW'(done), DW'(0));
        rd_stream("midreset rd", 0, 1, 2, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
